// File: rtl/ysyx_24080006_axi_rslv.sv
// AXI4 read-only slave backed by a preloadable word memory.
// One burst in flight; fixed access latency before the first beat, then one beat per accepted transfer.
module ysyx_24080006_axi_rslv #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     arvalid,
    output logic                     arready,
    input  logic [31:0]              araddr,
    input  logic [3:0]               arid,
    input  logic [7:0]               arlen,
    input  logic [2:0]               arsize,
    input  logic [1:0]               arburst,
    output logic                     rvalid,
    input  logic                     rready,
    output logic [31:0]              rdata,
    output logic [1:0]               rresp,
    output logic                     rlast,
    output logic [3:0]               rid,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_idx,
    input  logic [31:0]              ld_data
);

    localparam int          IW       = $clog2(DEPTH);
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);
    localparam logic [3:0]  LAT      = 4'(LATENCY);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DELAY = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;

    logic [1:0]  state, state_nx;
    logic [3:0]  dly_cnt;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [7:0]  beat;

    logic [31:0] mem [DEPTH];

    logic        hs, accept;
    logic [31:0] wrap_mask, next_addr;

    // Fields of the beat about to be latched into the R channel registers.
    logic        load;
    logic [31:0] f_addr;
    logic [7:0]  f_len, f_beat;
    logic [2:0]  f_size;
    logic [1:0]  f_burst;
    logic        f_wrap_ok, f_err;
    logic [IW-1:0] f_idx;
    logic [31:0] f_word;

    assign hs     = arvalid && arready;
    assign accept = rvalid && rready;

    // WRAP windows are (len+1)*4 bytes, i.e. {len, 2'b11} as a mask when len+1 is a power of two.
    assign wrap_mask = {22'd0, len, 2'b11};

    always_comb begin
        next_addr = addr + 32'd4;
        case (burst)
            2'd0: next_addr = addr;
            2'd2: if (len inside {8'd1, 8'd3, 8'd7, 8'd15})
                      next_addr = (addr & ~wrap_mask) | ((addr + 32'd4) & wrap_mask);
            default: next_addr = addr + 32'd4;
        endcase
    end

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        f_addr   = addr;
        f_len    = len;
        f_size   = size;
        f_burst  = burst;
        f_beat   = beat;
        case (state)
            IDLE: begin
                if (hs) begin
                    f_addr  = araddr;
                    f_len   = arlen;
                    f_size  = arsize;
                    f_burst = arburst;
                    f_beat  = 8'd0;
                    if (LATENCY == 0) begin
                        state_nx = DATA;
                        load     = 1'b1;
                    end else begin
                        state_nx = DELAY;
                    end
                end
            end
            DELAY: begin
                if (dly_cnt == LAT - 4'd1) begin
                    state_nx = DATA;
                    load     = 1'b1;
                end
            end
            DATA: begin
                if (accept) begin
                    if (rlast) begin
                        state_nx = IDLE;
                    end else begin
                        f_addr = next_addr;
                        f_beat = beat + 8'd1;
                        load   = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        f_wrap_ok = f_len inside {8'd1, 8'd3, 8'd7, 8'd15};
        f_err     = ({1'b0, f_addr} < {1'b0, BASE_ADDR}) || ({1'b0, f_addr} >= END_ADDR) ||
                    (f_size != 3'd2) || (f_burst == 2'd3) || (f_burst == 2'd2 && !f_wrap_ok);
        f_idx     = IW'((f_addr - BASE_ADDR) >> 2);
        // A preload landing on the same edge as the fetch is forwarded so the beat sees the new word.
        f_word    = (ld_en && ld_idx == f_idx) ? ld_data : mem[f_idx];
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rresp   <= 2'b00;
            rdata   <= 32'd0;
            rid     <= 4'd0;
            beat    <= 8'd0;
            dly_cnt <= 4'd0;
            addr    <= 32'd0;
            len     <= 8'd0;
            size    <= 3'd0;
            burst   <= 2'd0;
        end else begin
            state   <= state_nx;
            arready <= (state_nx == IDLE);
            if (state == DELAY)
                dly_cnt <= dly_cnt + 4'd1;
            if (hs) begin
                addr    <= araddr;
                len     <= arlen;
                size    <= arsize;
                burst   <= arburst;
                rid     <= arid;
                beat    <= 8'd0;
                dly_cnt <= 4'd0;
            end
            if (load) begin
                addr   <= f_addr;
                beat   <= f_beat;
                rvalid <= 1'b1;
                rdata  <= f_err ? 32'd0 : f_word;
                rresp  <= f_err ? 2'b10 : 2'b00;
                rlast  <= (f_beat == f_len);
            end else if (accept && rlast) begin
                rvalid <= 1'b0;
                rlast  <= 1'b0;
            end
        end
    end

    // NOTE: the memory array has no reset so its contents survive a reset and it maps onto RAM.
    always_ff @(posedge clock) begin
        if (ld_en)
            mem[ld_idx] <= ld_data;
    end

endmodule

// File: tb/tb_ysyx_24080006_axi_rslv.sv
// Directed bench for ysyx_24080006_axi_rslv: a burst-level model predicts every cycle's
// R/AR outputs, and literal expectations pin the model on the worked examples.
module tb_ysyx_24080006_axi_rslv;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 1024;
    localparam int          LAT   = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] araddr = '0;
    logic [3:0]  arid = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = 3'd2;
    logic [1:0]  arburst = 2'd1;
    logic        rvalid;
    logic        rready = 1'b1;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;
    logic        ld_en = 1'b0;
    logic [9:0]  ld_idx = '0;
    logic [31:0] ld_data = '0;

    ysyx_24080006_axi_rslv #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rid(rid),
        .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] addr;
        bit          err;
        bit          last;
        logic [3:0]  id;
    } beat_t;

    logic [31:0] mmem [DEPTH];
    beat_t       expq[$];
    bit          busy = 0;
    bit          rst_prev = 1;
    bit          fresh = 1;
    int          data_start = 0;
    int          cyc = 0;
    int          hs_cyc = 0;
    logic [31:0] held_data;
    logic [1:0]  held_resp;
    bit          exp_rv;
    bit          hs_now;

    logic [31:0] log_data[$];
    logic [1:0]  log_resp[$];
    bit          log_last[$];
    logic [3:0]  log_id[$];
    int          log_cyc[$];
    logic [31:0] gen_addr[$];

    // Expand a request into its beat list using plain address arithmetic.
    task automatic gen_beats(input logic [31:0] a0, input logic [7:0] len, input logic [2:0] sz,
                             input logic [1:0] bt, input logic [3:0] id);
        longint wsz = (longint'(len) + 1) * 4;
        bit bad_wrap = (bt == 2'd2) && !(len == 1 || len == 3 || len == 7 || len == 15);
        longint start = a0;
        gen_addr.delete();
        for (int i = 0; i <= int'(len); i++) begin
            beat_t b;
            longint a;
            if (bt == 2'd0)
                a = start;
            else if (bt == 2'd2 && !bad_wrap)
                a = (start - start % wsz) + ((start % wsz) + 4 * i) % wsz;
            else
                a = (start + 4 * i) % 64'h1_0000_0000;
            b.addr = 32'(a);
            b.err  = (a < longint'(BASE)) || (a >= longint'(BASE) + 4 * DEPTH) ||
                     (sz != 3'd2) || (bt == 2'd3) || bad_wrap;
            b.last = (i == int'(len));
            b.id   = id;
            expq.push_back(b);
            gen_addr.push_back(b.addr);
        end
    endtask

    always @(negedge clock) begin
        cyc++;
        exp_rv = busy && (cyc >= data_start);
        hs_now = !busy && !rst_prev && arvalid;
        check("arready", {31'd0, arready}, {31'd0, !busy && !rst_prev});
        check("rvalid", {31'd0, rvalid}, {31'd0, exp_rv});
        if (exp_rv && expq.size() > 0) begin
            if (fresh) begin
                held_data = expq[0].err ? 32'd0 : mmem[(expq[0].addr - BASE) >> 2];
                held_resp = expq[0].err ? 2'b10 : 2'b00;
                fresh = 0;
            end
            check("rdata", rdata, held_data);
            check("rresp", {30'd0, rresp}, {30'd0, held_resp});
            check("rlast", {31'd0, rlast}, {31'd0, expq[0].last});
            check("rid", {28'd0, rid}, {28'd0, expq[0].id});
        end
        if (ld_en)
            mmem[ld_idx] = ld_data;
        if (reset) begin
            expq.delete();
            busy  = 0;
            fresh = 1;
        end else begin
            if (exp_rv && rready && expq.size() > 0) begin
                log_data.push_back(rdata);
                log_resp.push_back(rresp);
                log_last.push_back(rlast);
                log_id.push_back(rid);
                log_cyc.push_back(cyc);
                void'(expq.pop_front());
                fresh = 1;
                if (expq.size() == 0)
                    busy = 0;
            end
            if (hs_now) begin
                gen_beats(araddr, arlen, arsize, arburst, arid);
                busy       = 1;
                fresh      = 1;
                data_start = cyc + LAT + 1;
                hs_cyc     = cyc;
            end
        end
        rst_prev = reset;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic preload(input int idx, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_idx  = 10'(idx);
        ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic clear_logs();
        log_data.delete();
        log_resp.delete();
        log_last.delete();
        log_id.delete();
        log_cyc.delete();
    endtask

    task automatic issue_ar(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                            input logic [1:0] bt, input logic [3:0] id);
        int n = 0;
        araddr  = a;
        arlen   = len;
        arsize  = sz;
        arburst = bt;
        arid    = id;
        arvalid = 1'b1;
        while (arready !== 1'b1) begin
            tick();
            n++;
            if (n > 50) begin
                checks++;
                failures++;
                $display("FAIL ar_wait: arready never rose within %0d cycles", n);
                break;
            end
        end
        tick();
        arvalid = 1'b0;
    endtask

    task automatic drain(input bit toggle);
        int n = 0;
        if (toggle)
            rready = 1'b0;
        while (busy) begin
            rready = toggle ? ~rready : 1'b1;
            tick();
            n++;
            if (n > 200) begin
                checks++;
                failures++;
                $display("FAIL drain: burst still open after %0d cycles", n);
                break;
            end
        end
        rready = 1'b1;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                           input logic [1:0] bt, input logic [3:0] id, input bit toggle);
        clear_logs();
        issue_ar(a, len, sz, bt, id);
        drain(toggle);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        for (int i = 0; i < DEPTH; i++)
            mmem[i] = 32'd0;
        repeat (3) tick();
        check("reset_arready", {31'd0, arready}, 32'd0);
        check("reset_rvalid", {31'd0, rvalid}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        reset = 1'b0;
        tick();
        check("arready_after_reset", {31'd0, arready}, 32'd1);

        preload(0, 32'hDEAD_BEEF);
        for (int i = 1; i < 32; i++)
            preload(i, 32'hA500_0000 + 32'(i));
        preload(1023, 32'h5555_AAAA);

        // Single read
        do_read(32'h8000_0000, 8'd0, 3'd2, 2'd1, 4'd5, 1'b0);
        check("single_beats", log_data.size(), 32'd1);
        if (log_data.size() == 1) begin
            check("single_data", log_data[0], 32'hDEAD_BEEF);
            check("single_resp", {30'd0, log_resp[0]}, 32'd0);
            check("single_last", {31'd0, log_last[0]}, 32'd1);
            check("single_id", {28'd0, log_id[0]}, 32'd5);
            check("single_latency", log_cyc[0] - hs_cyc, 32'd3);
        end
        check("single_arready_after", {31'd0, arready}, 32'd1);

        // INCR with back-pressure
        do_read(32'h8000_0008, 8'd3, 3'd2, 2'd1, 4'd3, 1'b1);
        check("incr_beats", log_data.size(), 32'd4);
        if (log_data.size() == 4) begin
            check("incr_d0", log_data[0], 32'hA500_0002);
            check("incr_d1", log_data[1], 32'hA500_0003);
            check("incr_d2", log_data[2], 32'hA500_0004);
            check("incr_d3", log_data[3], 32'hA500_0005);
            check("incr_last_early", {31'd0, log_last[2]}, 32'd0);
            check("incr_last_final", {31'd0, log_last[3]}, 32'd1);
        end

        // WRAP burst
        do_read(32'h8000_0018, 8'd3, 3'd2, 2'd2, 4'd9, 1'b0);
        check("wrap_gen_a2", gen_addr[2], 32'h8000_0010);
        check("wrap_beats", log_data.size(), 32'd4);
        if (log_data.size() == 4) begin
            check("wrap_d0", log_data[0], 32'hA500_0006);
            check("wrap_d1", log_data[1], 32'hA500_0007);
            check("wrap_d2", log_data[2], 32'hA500_0004);
            check("wrap_d3", log_data[3], 32'hA500_0005);
        end

        // Error cases
        do_read(32'h7FFF_FFFC, 8'd1, 3'd2, 2'd0, 4'd1, 1'b0);
        check("below_beats", log_data.size(), 32'd2);
        if (log_data.size() == 2) begin
            check("below_r0", {30'd0, log_resp[0]}, 32'd2);
            check("below_d0", log_data[0], 32'd0);
            check("below_r1", {30'd0, log_resp[1]}, 32'd2);
            check("below_l0", {31'd0, log_last[0]}, 32'd0);
            check("below_l1", {31'd0, log_last[1]}, 32'd1);
        end
        do_read(32'h8000_0004, 8'd0, 3'd1, 2'd1, 4'd2, 1'b0);
        if (log_resp.size() == 1)
            check("size_resp", {30'd0, log_resp[0]}, 32'd2);
        else
            check("size_beats", log_resp.size(), 32'd1);
        do_read(32'h8000_0004, 8'd0, 3'd2, 2'd3, 4'd2, 1'b0);
        do_read(32'h8000_0004, 8'd2, 3'd2, 2'd2, 4'd4, 1'b0);
        check("badwrap_beats", log_data.size(), 32'd3);
        do_read(32'h8000_0FFC, 8'd1, 3'd2, 2'd1, 4'd6, 1'b0);
        if (log_data.size() == 2) begin
            check("top_d0", log_data[0], 32'h5555_AAAA);
            check("top_r1", {30'd0, log_resp[1]}, 32'd2);
        end else
            check("top_beats", log_data.size(), 32'd2);

        // Preload of a word already latched in rdata
        clear_logs();
        issue_ar(32'h8000_0004, 8'd1, 3'd2, 2'd0, 4'd7);
        rready = 1'b0;
        n = 0;
        while (rvalid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        preload(1, 32'hCAFE_F00D);
        check("hold_rdata", rdata, 32'hA500_0001);
        drain(1'b0);
        if (log_data.size() == 2) begin
            check("preload_old", log_data[0], 32'hA500_0001);
            check("preload_new", log_data[1], 32'hCAFE_F00D);
        end else
            check("preload_beats", log_data.size(), 32'd2);

        // Reset in the middle of a burst
        for (int i = 16; i < 24; i++)
            preload(i, 32'h3C00_0000 + 32'(i));
        clear_logs();
        issue_ar(32'h8000_0040, 8'd7, 3'd2, 2'd1, 4'd8);
        rready = 1'b1;
        n = 0;
        while (log_data.size() < 2 && n < 30) begin
            tick();
            n++;
        end
        check("pre_reset_beats", log_data.size(), 32'd2);
        reset = 1'b1;
        tick();
        check("reset_mid_rvalid", {31'd0, rvalid}, 32'd0);
        reset = 1'b0;
        repeat (5) tick();
        check("no_beats_after_reset", log_data.size(), 32'd2);
        do_read(32'h8000_0040, 8'd0, 3'd2, 2'd1, 4'd8, 1'b0);
        if (log_data.size() == 1)
            check("mem_retained", log_data[0], 32'h3C00_0010);
        else
            check("retained_beats", log_data.size(), 32'd1);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
